// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: flash read port toward memory and the valid/ready
// instruction port toward decode. The fetch unit is the master of both.
interface fetch_unit_if;
  logic        mem_read;
  logic [26:0] mem_addr;
  logic [31:0] mem_inst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  modport master (
    output mem_read, mem_addr, if_valid, if_inst, if_pc,
    input  mem_inst, if_ready
  );

  modport slave (
    input  mem_read, mem_addr, if_valid, if_inst, if_pc,
    output mem_inst, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency flash reads,
// buffers returns with their PCs and hands them to decode; handles redirect/halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          halt,
  output logic          fetch_idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t         state;
  logic [31:0]    pc;
  logic [31:0]    inflight_pc;
  logic           inflight;
  logic [31:0]    inst_buf [FIFO_DEPTH];
  logic [31:0]    pc_buf   [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  occ;
  logic [31:0]    last_inst;
  logic [31:0]    last_pc;
  logic           fifo_empty;
  logic           pop;
  logic           push;
  logic           issue;
  logic [CW:0]    credit;
  logic           redirect_low_unused;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect_low_unused = ^redirect_pc[1:0];

  assign fifo_empty   = (occ == '0);
  assign bus.if_valid = !fifo_empty && !redirect_valid;
  assign pop          = bus.if_valid && bus.if_ready;
  assign push         = inflight && !redirect_valid;

  // Credit counts buffered plus in-flight words, so a return always has a slot.
  assign credit = {1'b0, occ} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue  = (state == RUN) && !halt && !redirect_valid &&
                  (credit < (CW+1)'(FIFO_DEPTH));

  assign bus.mem_read = issue;
  assign bus.mem_addr = pc[28:2];
  assign bus.if_inst  = fifo_empty ? last_inst : inst_buf[rd_ptr];
  assign bus.if_pc    = fifo_empty ? last_pc   : pc_buf[rd_ptr];
  assign fetch_idle   = (state == HALT) && fifo_empty && !inflight;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      last_inst   <= 32'h0;
      last_pc     <= 32'h0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt)  state <= HALT;
        HALT:    if (!halt) state <= RUN;
        default: state <= BOOT;
      endcase

      if (redirect_valid)
        pc <= {redirect_pc[31:2], 2'b00};
      else if (issue)
        pc <= pc + 32'd4;

      inflight <= issue;
      if (issue)
        inflight_pc <= pc;

      if (pop) begin
        last_inst <= inst_buf[rd_ptr];
        last_pc   <= pc_buf[rd_ptr];
      end

      // A redirect drops both the buffered entries and the returning word.
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      inst_buf[wr_ptr] <= bus.mem_inst;
      pc_buf[wr_ptr]   <= inflight_pc;
    end
  end

  no_overflow: assert property (@(posedge clock) disable iff (!reset)
                                !(push && !pop && occ == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a flash model returning 0x1000_0000 + word
// address, stepped through stream, backpressure, redirect, halt and reset.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fetch_idle;
  logic [31:0] exp_pc;
  int          checks_done;
  int          checks_failed;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_idle     (fetch_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flash returns data one cycle after the strobe; junk otherwise.
  always @(posedge clock)
    bus.mem_inst <= bus.mem_read ? (32'h1000_0000 + {5'b0, bus.mem_addr}) : 32'hDEAD_BEEF;

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_done++;
    assert (observed === expected) else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
    @(negedge clock);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    bus.if_ready   = rdy;
    #1;
    if (bus.if_valid && bus.if_ready) begin
      checkOutput("stream_pc", bus.if_pc, exp_pc);
      checkOutput("stream_inst", bus.if_inst, 32'h1000_0000 + {5'b0, exp_pc[28:2]});
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    checks_done    = 0;
    checks_failed  = 0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    bus.if_ready   = 1'b1;
    exp_pc         = 32'h0;

    @(negedge clock);
    #1;
    checkOutput("rst_mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_if_inst", bus.if_inst, 32'h0);
    checkOutput("rst_if_pc", bus.if_pc, 32'h0);
    checkOutput("rst_idle", 32'(fetch_idle), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("boot_no_read", 32'(bus.mem_read), 32'd0);

    // First read one cycle after BOOT, first instruction two cycles later
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("first_read", 32'(bus.mem_read), 32'd1);
    checkOutput("first_addr", 32'(bus.mem_addr), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("latency_not_yet", 32'(bus.if_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("first_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("first_inst", bus.if_inst, 32'h1000_0000);
    checkOutput("first_pc", bus.if_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("throughput_valid", 32'(bus.if_valid), 32'd1);
    end

    // Backpressure for five cycles with pc 0x14 at the head
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("bp_no_read", 32'(bus.mem_read), 32'd0);
    checkOutput("bp_head_pc", bus.if_pc, 32'h14);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("bp_valid", 32'(bus.if_valid), 32'd1);
      checkOutput("bp_frozen_pc", bus.if_pc, 32'h14);
      checkOutput("bp_frozen_inst", bus.if_inst, 32'h1000_0005);
      checkOutput("bp_no_read", 32'(bus.mem_read), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("bp_resume_read", 32'(bus.mem_read), 32'd1);
    checkOutput("bp_resume_addr", 32'(bus.mem_addr), 32'd7);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect with one entry buffered and one read in flight
    applyStimulus(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    checkOutput("redir_valid_low", 32'(bus.if_valid), 32'd0);
    checkOutput("redir_no_read", 32'(bus.mem_read), 32'd0);
    exp_pc = 32'h100;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_read", 32'(bus.mem_read), 32'd1);
    checkOutput("redir_addr", 32'(bus.mem_addr), 32'h40);
    checkOutput("redir_flushed", 32'(bus.if_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_no_stale", 32'(bus.if_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("redir_first_pc", bus.if_pc, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Halt for four cycles: drain, go idle, keep pc 0x110
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_no_read", 32'(bus.mem_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_drain_valid", 32'(bus.if_valid), 32'd1);
    checkOutput("halt_not_idle", 32'(fetch_idle), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_empty", 32'(bus.if_valid), 32'd0);
    checkOutput("halt_idle", 32'(fetch_idle), 32'd1);
    checkOutput("empty_hold_pc", bus.if_pc, 32'h10C);
    checkOutput("empty_hold_inst", bus.if_inst, 32'h1000_0043);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_idle2", 32'(fetch_idle), 32'd1);
    checkOutput("halt_pc_kept", 32'(bus.mem_addr), 32'h44);
    checkOutput("halt_no_read2", 32'(bus.mem_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("unhalt_wait", 32'(bus.mem_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume_read", 32'(bus.mem_read), 32'd1);
    checkOutput("resume_addr", 32'(bus.mem_addr), 32'h44);
    checkOutput("resume_not_idle", 32'(fetch_idle), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect and halt in the same cycle
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    checkOutput("rh_valid_low", 32'(bus.if_valid), 32'd0);
    checkOutput("rh_no_read", 32'(bus.mem_read), 32'd0);
    exp_pc = 32'h200;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rh_halted_read", 32'(bus.mem_read), 32'd0);
    checkOutput("rh_target_addr", 32'(bus.mem_addr), 32'h80);
    checkOutput("rh_idle", 32'(fetch_idle), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("rh_unhalt_wait", 32'(bus.mem_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("rh_resume_read", 32'(bus.mem_read), 32'd1);
    checkOutput("rh_resume_addr", 32'(bus.mem_addr), 32'h80);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("rh_first_pc", bus.if_pc, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset while streaming
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("async_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("async_if_inst", bus.if_inst, 32'h0);
    checkOutput("async_if_pc", bus.if_pc, 32'h0);
    checkOutput("async_idle", 32'(fetch_idle), 32'd0);
    exp_pc = 32'h0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("reboot_no_read", 32'(bus.mem_read), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("reboot_read", 32'(bus.mem_read), 32'd1);
    checkOutput("reboot_addr", 32'(bus.mem_addr), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("reboot_wait", 32'(bus.if_valid), 32'd0);
    checkOutput("reboot_hold_inst", bus.if_inst, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("reboot_first_pc", bus.if_pc, 32'h0);
    checkOutput("reboot_first_inst", bus.if_inst, 32'h1000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks_done, checks_failed);
    $finish;
  end

endmodule
